// File: rtl/uart_frame_pkg.sv
// Shared types and constants for uart_frame_sender.
// Define FRAME_CKSUM_EN to append an 8-bit additive checksum byte to every frame.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_GAP,
    ST_ABORT
  } state_t;

  localparam int         DEF_NUM_WORDS = 6;
  localparam logic [7:0] DEF_HEADER0   = 8'h55;
  localparam logic [7:0] DEF_HEADER1   = 8'hAA;
  localparam int         HDR_BYTES     = 2;

`ifdef FRAME_CKSUM_EN
  localparam int CKSUM_BYTES = 1;
`else
  localparam int CKSUM_BYTES = 0;
`endif

  function automatic int frame_len(input int num_words);
    return HDR_BYTES + 2 * num_words + CKSUM_BYTES;
  endfunction

  // The byte index must be able to reach frame_len itself (the "frame done" value).
  function automatic int idx_width(input int num_words);
    return $clog2(frame_len(num_words) + 1);
  endfunction

endpackage

// File: rtl/uart_frame_sender_if.sv
// Sample-in / byte-out signal bundle for uart_frame_sender.
// master = the frame sender itself, slave = its sensor/UART neighbours.
interface uart_frame_sender_if #(
  parameter int NUM_WORDS = 6
);
  logic                     s_valid;
  logic                     s_ready;
  logic [16*NUM_WORDS-1:0]  s_data;
  logic [7:0]               tx_data;
  logic                     tx_send;
  logic                     tx_done;
  logic                     busy;
  logic                     frame_err;

  modport master (
    input  s_valid, s_data, tx_done,
    output s_ready, tx_data, tx_send, busy, frame_err
  );

  modport slave (
    output s_valid, s_data, tx_done,
    input  s_ready, tx_data, tx_send, busy, frame_err
  );
endinterface

// File: rtl/uart_frame_sender.sv
// Frames one multi-word sensor sample into header + MSB-first data bytes for a byte UART.
// Define FRAME_CKSUM_EN to append the mod-256 sum of all preceding frame bytes.
module uart_frame_sender
  import uart_frame_pkg::*;
#(
  parameter int         NUM_WORDS      = DEF_NUM_WORDS,
  parameter logic [7:0] HEADER0        = DEF_HEADER0,
  parameter logic [7:0] HEADER1        = DEF_HEADER1,
  parameter int         GAP_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  uart_frame_sender_if.master bus
);

  localparam int FRAME_LEN = frame_len(NUM_WORDS);
  localparam int IDX_W     = idx_width(NUM_WORDS);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W     = $clog2(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(FRAME_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t                   state_reg,   state_next;
  logic [IDX_W-1:0]         idx_reg,     idx_next;
  logic [7:0]               tx_data_reg, tx_data_next;
  logic [TMO_W-1:0]         tmo_cnt_reg, tmo_cnt_next;
  logic [GAP_W-1:0]         gap_cnt_reg, gap_cnt_next;
  logic [16*NUM_WORDS-1:0]  sample_reg;

  logic                     accept;
  logic [7:0]               frame_bytes [FRAME_LEN];
  logic [7:0]               cur_byte;

  assign accept = (state_reg == ST_IDLE) && bus.s_valid;

  assign frame_bytes[0] = HEADER0;
  assign frame_bytes[1] = HEADER1;

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_bytes
      assign frame_bytes[HDR_BYTES + 2*gi]     = sample_reg[16*gi + 8 +: 8];
      assign frame_bytes[HDR_BYTES + 2*gi + 1] = sample_reg[16*gi     +: 8];
    end
  endgenerate

`ifdef FRAME_CKSUM_EN
  logic [7:0] cksum_reg;

  // The trailing slot reads the running sum, which by then covers every earlier byte.
  assign frame_bytes[FRAME_LEN-1] = cksum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum_reg <= '0;
    end else if (accept) begin
      cksum_reg <= '0;
    end else if (state_reg == ST_LOAD && idx_reg != IDX_W'(FRAME_LEN - 1)) begin
      cksum_reg <= cksum_reg + cur_byte;
    end
  end
`endif

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (idx_reg == IDX_W'(i)) cur_byte = frame_bytes[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      tx_data_reg <= '0;
      tmo_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      sample_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      tx_data_reg <= tx_data_next;
      tmo_cnt_reg <= tmo_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      if (accept) sample_reg <= bus.s_data;
    end
  end

  // tx_data only moves in LOAD, where tx_send is low, so the UART never re-latches a torn byte.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    tx_data_next = tx_data_reg;
    tmo_cnt_next = tmo_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.s_valid) begin
          idx_next   = '0;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_data_next = cur_byte;
        tmo_cnt_next = '0;
        state_next   = ST_SEND;
      end
      ST_SEND: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the expiry clock still counts as success.
        if (bus.tx_done) begin
          idx_next     = idx_reg + IDX_W'(1);
          gap_cnt_next = '0;
          state_next   = ST_GAP;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = ST_ABORT;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
      end
      ST_ABORT: begin
        idx_next     = IDX_END;
        gap_cnt_next = '0;
        state_next   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = (idx_reg < IDX_END) ? ST_LOAD : ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.s_ready   = (state_reg == ST_IDLE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.tx_send   = (state_reg == ST_SEND) || (state_reg == ST_WAIT);
  assign bus.frame_err = (state_reg == ST_ABORT);
  assign bus.tx_data   = tx_data_reg;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Randomized bench for uart_frame_sender: reference frame model, UART responder, per-cycle checker.
module tb_uart_frame_sender;

  localparam int NW   = 6;
  localparam int GAP  = 2;
  localparam int TMO  = 50;
`ifdef FRAME_CKSUM_EN
  localparam int FLEN = 2 + 2*NW + 1;
`else
  localparam int FLEN = 2 + 2*NW;
`endif

  logic clk;
  logic rst;

  uart_frame_sender_if #(.NUM_WORDS(NW)) bif ();

  uart_frame_sender #(
    .NUM_WORDS      (NW),
    .HEADER0        (8'h55),
    .HEADER1        (8'hAA),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int err_count = 0;

  logic [7:0] exp_q [$];
  logic [7:0] cap_q [$];

  // UART responder knobs
  int fixed_delay    = 20;
  int withhold_byte  = -1;
  int override_byte  = -1;
  int override_delay = 0;
  bit stray_en       = 1'b0;
  int byte_no        = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  // Byte k of the frame built from sample d: headers, words MSB first, optional sum.
  function automatic logic [7:0] frame_byte(input logic [16*NW-1:0] d, input int k);
    int w;
    logic [7:0] sum;
    if (k == 0) return 8'h55;
    if (k == 1) return 8'hAA;
    if (k < 2 + 2*NW) begin
      w = (k - 2) / 2;
      return ((k - 2) % 2 == 0) ? d[16*w + 8 +: 8] : d[16*w +: 8];
    end
    sum = 8'h55 + 8'hAA;
    for (int j = 0; j < NW; j++) sum = sum + d[16*j + 8 +: 8] + d[16*j +: 8];
    return sum;
  endfunction

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART responder: pulses tx_done after a per-byte delay, optional stray pulses while idle.
  initial begin : uart_model
    int cnt;
    int d;
    bit in_byte;
    cnt = 0; d = 0; in_byte = 1'b0;
    bif.tx_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      bif.tx_done = 1'b0;
      if (!bif.busy) byte_no = 0;
      if (bif.tx_send && !in_byte) begin
        in_byte = 1'b1;
        cnt = 0;
        byte_no++;
        if (byte_no == withhold_byte)      d = 0;
        else if (byte_no == override_byte) d = override_delay;
        else if (fixed_delay > 0)          d = fixed_delay;
        else                               d = int'($urandom_range(1, 30));
      end else if (bif.tx_send && in_byte) begin
        cnt++;
        if (d != 0 && cnt == d) bif.tx_done = 1'b1;
      end else begin
        in_byte = 1'b0;
        if (stray_en && $urandom_range(0, 2) == 0) bif.tx_done = 1'b1;
      end
    end
  end

  // Per-cycle checker against the frame model and the timing rules.
  initial begin : compare
    bit prev_send, prev_ready, done_seen, first_pending, exp_err;
    logic [7:0] prev_data;
    int low_run, hi_run, accept_cyc, last_evt_cyc;
    prev_send = 0; prev_ready = 1; done_seen = 0; first_pending = 0; exp_err = 0;
    prev_data = '0; low_run = 0; hi_run = 0; accept_cyc = 0; last_evt_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_send = 0; prev_ready = 1; done_seen = 0; first_pending = 0;
        low_run = 0; hi_run = 0;
        check("rst_tx_send",   32'(bif.tx_send),   0);
        check("rst_s_ready",   32'(bif.s_ready),   1);
        check("rst_busy",      32'(bif.busy),      0);
        check("rst_frame_err", 32'(bif.frame_err), 0);
        continue;
      end
      exp_err = prev_send && (hi_run == TMO + 1) && !done_seen;
      check("frame_err", 32'(bif.frame_err), 32'(exp_err));
      if (bif.frame_err) begin
        exp_q.delete();
        last_evt_cyc = cyc;
        err_count++;
      end
      check("s_ready_vs_busy", 32'(bif.s_ready), 32'(!bif.busy));
      if (bif.tx_send && !prev_send) begin
        if (first_pending) check("first_byte_latency", cyc - accept_cyc, 2);
        else               check("gap_low_run", low_run, GAP + 1);
        first_pending = 0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, no byte expected", bif.tx_data);
        end else begin
          check("byte", 32'(bif.tx_data), 32'(exp_q.pop_front()));
        end
        cap_q.push_back(bif.tx_data);
        hi_run = 1;
        done_seen = 0;
      end else if (bif.tx_send) begin
        check("tx_data_stable", 32'(bif.tx_data), 32'(prev_data));
        hi_run++;
      end else begin
        hi_run = 0;
      end
      if (bif.tx_send && hi_run >= 2 && bif.tx_done) begin
        done_seen = 1;
        last_evt_cyc = cyc;
      end
      if (bif.s_ready && !prev_ready) begin
        check("idle_after_gap", cyc - last_evt_cyc, GAP + 1);
        check("frame_complete", exp_q.size(), 0);
      end
      if (bif.s_valid && bif.s_ready) begin
        for (int k = 0; k < FLEN; k++) exp_q.push_back(frame_byte(bif.s_data, k));
        accept_cyc = cyc;
        first_pending = 1;
      end
      low_run   = bif.tx_send ? 0 : low_run + 1;
      prev_send = bif.tx_send;
      prev_data = bif.tx_data;
      prev_ready = bif.s_ready;
    end
  end

  task automatic send_sample(input logic [16*NW-1:0] d);
    bit ok;
    ok = 0;
    bif.s_data  = d;
    bif.s_valid = 1'b1;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (bif.s_ready && !rst) ok = 1;
    end
    @(posedge clk); #2;
    bif.s_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: sample not accepted within 5000 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(posedge clk); #3;
      if (!bif.busy) ok = 1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: busy still high after 5000 cycles");
    end
  endtask

  function automatic logic [16*NW-1:0] rand_sample();
    logic [16*NW-1:0] d;
    for (int i = 0; i < NW; i++) d[16*i +: 16] = 16'($urandom);
    return d;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [16*NW-1:0] d1;
    logic [7:0] lit1 [15];
    int errs_before;
    bit ok;

    d1 = {16'h0B0C, 16'h090A, 16'h0708, 16'h0506, 16'h0304, 16'h0102};
    lit1 = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h4D};

    rst = 1'b1;
    bif.s_valid = 1'b0;
    bif.s_data  = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_data", 32'(bif.tx_data), 0);
    rst = 1'b0;

    // Fixed sample, fixed 20-clk UART, compare against hand-computed bytes.
    for (int k = 0; k < FLEN; k++) check("model_pin", 32'(frame_byte(d1, k)), 32'(lit1[k]));
    cap_q.delete();
    send_sample(d1);
    wait_idle();
    check("frame1_len", cap_q.size(), FLEN);
    for (int k = 0; k < FLEN && k < cap_q.size(); k++) check("frame1_byte", 32'(cap_q[k]), 32'(lit1[k]));

    // Random samples back to back, random UART delays, stray done pulses in idle/gap.
    fixed_delay = 0;
    stray_en = 1'b1;
    cap_q.delete();
    errs_before = err_count;
    for (int n = 0; n < 6; n++) send_sample(rand_sample());
    wait_idle();
    check("random_total_bytes", cap_q.size(), 6 * FLEN);
    check("random_no_err", err_count - errs_before, 0);
    stray_en = 1'b0;

    // Withhold done on byte 3: frame aborts after the timeout.
    withhold_byte = 3;
    cap_q.delete();
    errs_before = err_count;
    send_sample(rand_sample());
    wait_idle();
    check("timeout_err_pulses", err_count - errs_before, 1);
    check("timeout_bytes_sent", cap_q.size(), 3);
    check("timeout_s_ready", 32'(bif.s_ready), 1);
    withhold_byte = -1;

    // Done exactly on the expiry clock of byte 4: frame continues.
    override_byte  = 4;
    override_delay = TMO;
    cap_q.delete();
    errs_before = err_count;
    send_sample(rand_sample());
    wait_idle();
    check("edge_timeout_no_err", err_count - errs_before, 0);
    check("edge_timeout_len", cap_q.size(), FLEN);
    override_byte = -1;

    // Reset while byte 5 is on the wire, then a clean frame.
    fixed_delay = 20;
    send_sample(rand_sample());
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk); #3;
      if (byte_no == 5 && bif.tx_send) ok = 1;
    end
    check("reach_byte5", 32'(ok), 1);
    rst = 1'b1;
    #1;
    check("rst_drops_send", 32'(bif.tx_send), 0);
    check("rst_clears_busy", 32'(bif.busy), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", 32'(bif.s_ready), 1);
    cap_q.delete();
    send_sample(rand_sample());
    wait_idle();
    check("post_rst_len", cap_q.size(), FLEN);
    if (cap_q.size() > 0) check("post_rst_hdr0", 32'(cap_q[0]), 32'h55);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
